jtframe_db15_scan: RTL and testbench

//  Serial reader for the DB15 joystick adapter (74HC165 shift-register chain) on clk_sys.

---
 rtl/jtframe_db15_pkg.sv | 16 +
 rtl/jtframe_db15_scan_if.sv | 22 ++
 rtl/jtframe_db15_tick.sv | 24 ++
 rtl/jtframe_db15_scan.sv | 127 ++++++++++++
 tb/tb_jtframe_db15_scan.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/jtframe_db15_pkg.sv
// Shared types and counter widths for the DB15 joystick scanner.
package jtframe_db15_pkg;

    typedef enum logic [2:0] {
        ST_GAP,
        ST_LOAD,
        ST_SAMPLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    localparam int unsigned TICK_W = 8;
    localparam int unsigned GAP_W  = 10;
    localparam int unsigned IDX_W  = 5;

endpackage

// File: rtl/jtframe_db15_scan_if.sv
// Adapter pins plus decoded joystick words of the DB15 scanner.
interface jtframe_db15_scan_if;

    logic        JOY_CLK;
    logic        JOY_LOAD;
    logic        JOY_DATA;
    logic [15:0] joystick1;
    logic [15:0] joystick2;
    logic        osd_combo;
    logic        frame_done;

    modport master (
        output JOY_CLK, JOY_LOAD, joystick1, joystick2, osd_combo, frame_done,
        input  JOY_DATA
    );

    modport slave (
        input  JOY_CLK, JOY_LOAD, joystick1, joystick2, osd_combo, frame_done,
        output JOY_DATA
    );

endinterface

// File: rtl/jtframe_db15_tick.sv
// Free-running prescaler: one-cycle tick every CLKDIV clk_sys cycles.
module jtframe_db15_tick import jtframe_db15_pkg::*; #(
    parameter int unsigned CLKDIV = 8
) (
    input  logic clk_sys,
    input  logic rst_n,
    output logic o_tick
);

    logic [TICK_W-1:0] r_cnt;

    assign o_tick = (r_cnt == TICK_W'(CLKDIV - 1));

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/jtframe_db15_scan.sv
// DB15 adapter reader: shifts in two players from a 74HC165 chain and
// publishes a frame only when it matches the previous one.
module jtframe_db15_scan import jtframe_db15_pkg::*; #(
    parameter int unsigned CLKDIV = 8,
    parameter int unsigned NBITS  = 12,
    parameter int unsigned GAP    = 64
) (
    input  logic                clk_sys,
    input  logic                rst_n,
    jtframe_db15_scan_if.master bus
);

    localparam int unsigned FW = 2 * NBITS;

    logic             w_tick;
    state_t           r_state, w_state_nx;
    logic [GAP_W-1:0] r_gap, w_gap_nx;
    logic [IDX_W-1:0] r_idx, w_idx_nx;
    logic [IDX_W:0]   w_idx_inc;
    logic             w_last;
    logic [FW-1:0]    r_frame, r_prev, w_frame_nx;
    logic             r_primed;
    logic [1:0]       r_sync;
    logic             r_joy_clk, r_joy_load;
    logic [15:0]      r_joy1, r_joy2, w_new1, w_new2;
    logic             r_osd;
    logic             w_accept;

    jtframe_db15_tick #(
        .CLKDIV (CLKDIV)
    ) u_tick (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .o_tick  (w_tick)
    );

    assign w_idx_inc = {1'b0, r_idx} + 1'b1;
    assign w_last    = (w_idx_inc == (IDX_W + 1)'(FW));

    always_comb begin
        w_state_nx = r_state;
        w_gap_nx   = r_gap;
        w_idx_nx   = r_idx;
        case (r_state)
            ST_GAP: if (w_tick) begin
                if (r_gap == GAP_W'(GAP - 1)) begin
                    w_gap_nx   = '0;
                    w_state_nx = ST_LOAD;
                end else begin
                    w_gap_nx = r_gap + 1'b1;
                end
            end
            ST_LOAD: if (w_tick) begin
                w_idx_nx   = '0;
                w_state_nx = ST_SAMPLE;
            end
            ST_SAMPLE: if (w_tick) w_state_nx = ST_SHIFT;
            ST_SHIFT: if (w_tick) begin
                w_idx_nx   = w_idx_inc[IDX_W-1:0];
                w_state_nx = w_last ? ST_DONE : ST_SAMPLE;
            end
            ST_DONE: w_state_nx = ST_GAP;
            default: w_state_nx = ST_GAP;
        endcase
    end

    // Adapter data is active low; store pressed buttons as 1.
    always_comb begin
        w_frame_nx = r_frame;
        for (int i = 0; i < int'(FW); i++) begin
            if (r_idx == IDX_W'(i)) w_frame_nx[i] = ~r_sync[1];
        end
    end

    always_comb begin
        w_new1 = '0;
        w_new2 = '0;
        for (int i = 0; i < int'(NBITS); i++) begin
            w_new1[i] = r_frame[i];
            w_new2[i] = r_frame[NBITS + i];
        end
        w_accept = (r_state == ST_DONE) && r_primed && (r_frame == r_prev);
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_GAP;
            r_gap      <= '0;
            r_idx      <= '0;
            r_frame    <= '0;
            r_prev     <= '0;
            r_primed   <= 1'b0;
            r_sync     <= 2'b11;
            r_joy_clk  <= 1'b0;
            r_joy_load <= 1'b1;
            r_joy1     <= '0;
            r_joy2     <= '0;
            r_osd      <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_gap      <= w_gap_nx;
            r_idx      <= w_idx_nx;
            r_sync     <= {r_sync[0], bus.JOY_DATA};
            // Pins follow the next state so they only move on tick edges.
            r_joy_load <= (w_state_nx != ST_LOAD);
            r_joy_clk  <= (w_state_nx == ST_SHIFT);
            if (r_state == ST_SAMPLE && w_tick) r_frame <= w_frame_nx;
            if (r_state == ST_DONE) begin
                r_prev   <= r_frame;
                r_primed <= 1'b1;
            end
            if (w_accept) begin
                r_joy1 <= w_new1;
                r_joy2 <= w_new2;
                r_osd  <= w_new1[10] & w_new1[6];
            end
        end
    end

    assign bus.JOY_CLK    = r_joy_clk;
    assign bus.JOY_LOAD   = r_joy_load;
    assign bus.joystick1  = r_joy1;
    assign bus.joystick2  = r_joy2;
    assign bus.osd_combo  = r_osd;
    assign bus.frame_done = (r_state == ST_DONE);

endmodule

// File: tb/tb_jtframe_db15_scan.sv
// Directed bench: adapter model on a CLKDIV=4 scanner plus a CLKDIV=1, 16-bit one.
module tb_jtframe_db15_scan;

    logic clk_sys = 1'b0;
    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    logic [31:0] pat_a = 32'h0;
    logic [31:0] sr_a  = 32'h0;
    int          pos_a = 32;
    int          rises_a = 0;
    int          rises_b = 0;
    int          overlap_b = 0;

    localparam logic [31:0] PAT_NORM  = {8'h00, 12'h3C0, 12'h0A5};
    localparam logic [31:0] PAT_GLTCH = {8'h00, 12'h3C0, 12'h0A4};
    localparam logic [31:0] PAT_OSD   = {8'h00, 12'h3C0, 12'h4E5};

    always #5 clk_sys = ~clk_sys;

    jtframe_db15_scan_if if_a ();
    jtframe_db15_scan_if if_b ();

    jtframe_db15_scan #(.CLKDIV(4), .NBITS(12), .GAP(8)) u_dut_a (
        .clk_sys (clk_sys),
        .rst_n   (rst_a_n),
        .bus     (if_a)
    );

    jtframe_db15_scan #(.CLKDIV(1), .NBITS(16), .GAP(8)) u_dut_b (
        .clk_sys (clk_sys),
        .rst_n   (rst_b_n),
        .bus     (if_b)
    );

    // 74HC165 chain model: latch on load, advance on each clock rise, active-low out.
    always @(negedge if_a.JOY_LOAD) begin
        sr_a    = pat_a;
        pos_a   = 0;
        rises_a = 0;
    end
    always @(posedge if_a.JOY_CLK) begin
        pos_a   = pos_a + 1;
        rises_a = rises_a + 1;
    end
    assign if_a.JOY_DATA = (pos_a < 32) ? ~sr_a[pos_a] : 1'b1;

    assign if_b.JOY_DATA = 1'b1;
    always @(negedge if_b.JOY_LOAD) rises_b = 0;
    always @(posedge if_b.JOY_CLK) rises_b = rises_b + 1;
    always @(negedge clk_sys) if (!if_b.JOY_LOAD && if_b.JOY_CLK) overlap_b = overlap_b + 1;

    task automatic wait_done(input bit sel_b, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk_sys); #1;
            if ((sel_b ? if_b.frame_done : if_a.frame_done) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_total++;
            $display("FAIL frame_done_timeout: no pulse within 2000 cycles, required one");
        end
    endtask

    // Returns one cycle after frame_done, when accepted outputs are visible.
    task automatic next_frame_a();
        bit ok;
        wait_done(1'b0, ok);
        @(posedge clk_sys); #1;
    endtask

    task automatic count_to_load_a(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk_sys); n++; #1;
            if (if_a.JOY_LOAD === 1'b0) break;
        end
    endtask

    task automatic test_reset();
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        n_total++; if (if_a.JOY_CLK !== 1'b0) $display("FAIL rst_joy_clk: got %b, expected 0", if_a.JOY_CLK); else n_pass++;
        n_total++; if (if_a.JOY_LOAD !== 1'b1) $display("FAIL rst_joy_load: got %b, expected 1", if_a.JOY_LOAD); else n_pass++;
        n_total++; if (if_a.joystick1 !== 16'h0) $display("FAIL rst_joy1: got %h, expected 0000", if_a.joystick1); else n_pass++;
        n_total++; if (if_a.joystick2 !== 16'h0) $display("FAIL rst_joy2: got %h, expected 0000", if_a.joystick2); else n_pass++;
        n_total++; if (if_a.osd_combo !== 1'b0) $display("FAIL rst_osd: got %b, expected 0", if_a.osd_combo); else n_pass++;
        n_total++; if (if_a.frame_done !== 1'b0) $display("FAIL rst_done: got %b, expected 0", if_a.frame_done); else n_pass++;
    endtask

    task automatic test_idle();
        int n;
        pat_a = 32'h0;
        @(negedge clk_sys);
        rst_a_n = 1'b1;
        count_to_load_a(n);
        n_total++; if (n !== 32) $display("FAIL idle_first_load: got %0d cycles, expected 32", n); else n_pass++;
        for (int f = 0; f < 2; f++) begin
            next_frame_a();
            n_total++; if (rises_a !== 24) $display("FAIL idle_rises: got %0d, expected 24", rises_a); else n_pass++;
            n_total++; if (if_a.joystick1 !== 16'h0 || if_a.joystick2 !== 16'h0)
                $display("FAIL idle_outputs: got %h/%h, expected 0000/0000", if_a.joystick1, if_a.joystick2);
            else n_pass++;
        end
    endtask

    task automatic test_debounce();
        pat_a = PAT_NORM;
        next_frame_a();
        n_total++; if (if_a.joystick1 !== 16'h0) $display("FAIL db_frame1_joy1: got %h, expected 0000", if_a.joystick1); else n_pass++;
        n_total++; if (if_a.joystick2 !== 16'h0) $display("FAIL db_frame1_joy2: got %h, expected 0000", if_a.joystick2); else n_pass++;
        next_frame_a();
        n_total++; if (if_a.joystick1 !== 16'h00A5) $display("FAIL db_frame2_joy1: got %h, expected 00a5", if_a.joystick1); else n_pass++;
        n_total++; if (if_a.joystick2 !== 16'h03C0) $display("FAIL db_frame2_joy2: got %h, expected 03c0", if_a.joystick2); else n_pass++;
    endtask

    task automatic test_glitch();
        pat_a = PAT_GLTCH;
        next_frame_a();
        n_total++; if (if_a.joystick1 !== 16'h00A5) $display("FAIL glitch_f3: got %h, expected 00a5", if_a.joystick1); else n_pass++;
        pat_a = PAT_NORM;
        next_frame_a();
        n_total++; if (if_a.joystick1 !== 16'h00A5) $display("FAIL glitch_f4: got %h, expected 00a5", if_a.joystick1); else n_pass++;
        next_frame_a();
        n_total++; if (if_a.joystick1 !== 16'h00A5) $display("FAIL glitch_f5_joy1: got %h, expected 00a5", if_a.joystick1); else n_pass++;
        n_total++; if (if_a.joystick2 !== 16'h03C0) $display("FAIL glitch_f5_joy2: got %h, expected 03c0", if_a.joystick2); else n_pass++;
    endtask

    task automatic test_osd();
        pat_a = PAT_OSD;
        next_frame_a();
        n_total++; if (if_a.osd_combo !== 1'b0) $display("FAIL osd_press1: got %b, expected 0", if_a.osd_combo); else n_pass++;
        next_frame_a();
        n_total++; if (if_a.joystick1 !== 16'h04E5) $display("FAIL osd_press2_joy1: got %h, expected 04e5", if_a.joystick1); else n_pass++;
        n_total++; if (if_a.osd_combo !== 1'b1) $display("FAIL osd_press2: got %b, expected 1", if_a.osd_combo); else n_pass++;
        pat_a = PAT_NORM;
        next_frame_a();
        n_total++; if (if_a.osd_combo !== 1'b1) $display("FAIL osd_release1: got %b, expected 1", if_a.osd_combo); else n_pass++;
        next_frame_a();
        n_total++; if (if_a.osd_combo !== 1'b0) $display("FAIL osd_release2: got %b, expected 0", if_a.osd_combo); else n_pass++;
        n_total++; if (if_a.joystick1 !== 16'h00A5) $display("FAIL osd_release2_joy1: got %h, expected 00a5", if_a.joystick1); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int n;
        bit seen_load;
        seen_load = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk_sys); #1;
            if (if_a.JOY_LOAD === 1'b0) seen_load = 1'b1;
            if (seen_load && rises_a == 7) break;
        end
        n_total++; if (rises_a !== 7) $display("FAIL mid_reach_bit7: got %0d rises, expected 7", rises_a); else n_pass++;
        repeat (5) @(posedge clk_sys);
        #2 rst_a_n = 1'b0;
        #1;
        n_total++; if (if_a.JOY_CLK !== 1'b0) $display("FAIL mid_joy_clk: got %b, expected 0", if_a.JOY_CLK); else n_pass++;
        n_total++; if (if_a.JOY_LOAD !== 1'b1) $display("FAIL mid_joy_load: got %b, expected 1", if_a.JOY_LOAD); else n_pass++;
        n_total++; if (if_a.joystick1 !== 16'h0 || if_a.joystick2 !== 16'h0)
            $display("FAIL mid_outputs: got %h/%h, expected 0000/0000", if_a.joystick1, if_a.joystick2);
        else n_pass++;
        repeat (4) @(negedge clk_sys);
        rst_a_n = 1'b1;
        count_to_load_a(n);
        n_total++; if (n !== 32) $display("FAIL mid_restart_load: got %0d cycles, expected 32", n); else n_pass++;
        next_frame_a();
        n_total++; if (rises_a !== 24) $display("FAIL mid_restart_rises: got %0d, expected 24", rises_a); else n_pass++;
        n_total++; if (if_a.joystick1 !== 16'h0) $display("FAIL mid_first_frame: got %h, expected 0000", if_a.joystick1); else n_pass++;
        next_frame_a();
        n_total++; if (if_a.joystick1 !== 16'h00A5) $display("FAIL mid_second_frame: got %h, expected 00a5", if_a.joystick1); else n_pass++;
    endtask

    task automatic test_fast();
        int n;
        bit ok;
        @(negedge clk_sys);
        rst_b_n = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk_sys); n++; #1;
            if (if_b.JOY_LOAD === 1'b0) break;
        end
        n_total++; if (n !== 8) $display("FAIL fast_first_load: got %0d cycles, expected 8", n); else n_pass++;
        wait_done(1'b1, ok);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk_sys); n++; #1;
            if (if_b.frame_done === 1'b1) break;
        end
        n_total++; if (n !== 74) $display("FAIL fast_period: got %0d cycles, expected 74", n); else n_pass++;
        n_total++; if (rises_b !== 32) $display("FAIL fast_rises: got %0d, expected 32", rises_b); else n_pass++;
        n_total++; if (overlap_b !== 0) $display("FAIL fast_load_clk_overlap: got %0d cycles, expected 0", overlap_b); else n_pass++;
        n_total++; if (if_b.joystick1 !== 16'h0) $display("FAIL fast_joy1: got %h, expected 0000", if_b.joystick1); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_debounce();
        test_glitch();
        test_osd();
        test_reset_mid();
        test_fast();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
